// File: rtl/spi_frame_packer_if.sv
// spi_frame_packer_if: bundles the count input, the byte handshake towards the
// SPI transmitter and the status/flag outputs of spi_frame_packer.
//   cnt_data/cnt_valid : count result and its one-cycle qualifier
//   data/sendEnable    : byte offered to the transmitter and its request
//   BUSY               : transmitter busy (high from acceptance to shift-out end)
//   Status             : 00 IDLE, 01 REQ, 10 SHIFT, 11 ABORT
//   frame_done         : one-cycle pulse when the 6th byte has completed
//   overrun/err        : sticky dropped-result and aborted-frame flags
// master = the packer, slave = the environment (counter + transmitter).
interface spi_frame_packer_if;
  logic [31:0] cnt_data;
  logic        cnt_valid;
  logic [7:0]  data;
  logic        sendEnable;
  logic        BUSY;
  logic [1:0]  Status;
  logic        frame_done;
  logic        overrun;
  logic        err;

  modport master (
    input  cnt_data, cnt_valid, BUSY,
    output data, sendEnable, Status, frame_done, overrun, err
  );

  modport slave (
    output cnt_data, cnt_valid, BUSY,
    input  data, sendEnable, Status, frame_done, overrun, err
  );
endinterface

// File: rtl/spi_frame_packer.sv
// spi_frame_packer: latches a 32-bit frequency count and sends it to the SPI
// byte transmitter as a 6-byte frame: SYNC_BYTE, count MSB first, XOR checksum
// of the four count bytes.
// Ports: clk (rising edge), rst (synchronous, active low), bus (master modport
// of spi_frame_packer_if, see that file for the signal list).
//
// Handshake: in REQ, sendEnable is high and data holds the current byte; a
// BUSY=1 sample means the transmitter took the byte. In SHIFT, sendEnable is
// low and data is held until BUSY=0 is sampled, which completes the byte.
// sendEnable stays high at most ACK_TIMEOUT cycles before the frame aborts.
module spi_frame_packer #(
  parameter int          COUNT_W     = 32,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  spi_frame_packer_if.master bus
);

  if (COUNT_W != 32) begin : g_count_w_check
    $error("spi_frame_packer: COUNT_W must be 32");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_timeout_check
    $error("spi_frame_packer: ACK_TIMEOUT must be in 1..65535");
  end

  // Encoding doubles as the Status output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_SHIFT = 2'b10,
    ST_ABORT = 2'b11
  } state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  LAST_IDX     = 3'd5;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  data_q, data_d;
  logic        overrun_q, overrun_d;
  logic        err_q, err_d;
  logic        done;

  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [31:0] s);
    logic [7:0] b;
    case (i)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = s[31:24];
      3'd2:    b = s[23:16];
      3'd3:    b = s[15:8];
      3'd4:    b = s[7:0];
      3'd5:    b = s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      timer_q   <= 16'd0;
      shadow_q  <= 32'd0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = 16'd0;          // only counts while waiting in REQ
    shadow_d  = shadow_q;
    data_d    = data_q;
    // Any result arriving outside IDLE is lost, including the frame_done cycle.
    overrun_d = overrun_q | (bus.cnt_valid && (state_q != ST_IDLE));
    err_d     = err_q;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cnt_valid) begin
          shadow_d = bus.cnt_data;
          idx_d    = 3'd0;
          data_d   = SYNC_BYTE;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.BUSY) begin
          state_d = ST_SHIFT;
        end else if (timer_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (!bus.BUSY) begin
          if (idx_q == LAST_IDX) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // data only moves on entry to REQ, so the transmitter never sees
            // it change under an open request or during a shift.
            idx_d   = idx_q + 3'd1;
            data_d  = frame_byte(idx_q + 3'd1, shadow_q);
            state_d = ST_REQ;
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.sendEnable = (state_q == ST_REQ);
  assign bus.Status     = state_q;
  assign bus.frame_done = done;
  assign bus.overrun    = overrun_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_spi_frame_packer.sv
// tb_spi_frame_packer: directed bench for spi_frame_packer (ACK_TIMEOUT=10).
// A background transmitter model accepts each byte (BUSY up 2 cycles after
// sendEnable, held 16 cycles), logs it and flags handshake violations; the
// test tasks compare against hand-computed expected bytes.
module tb_spi_frame_packer;
  logic clk;
  logic rst;

  spi_frame_packer_if bus();

  spi_frame_packer #(
    .COUNT_W     (32),
    .SYNC_BYTE   (8'hA5),
    .ACK_TIMEOUT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // transmitter model / monitor state (written only by the monitor process)
  logic [7:0] got_q[$];
  int         done_cnt = 0;
  int         hs_bad = 0;
  int         mon_phase = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_cap = 8'h00;
  logic       mon_nb = 1'b0;
  // written only by the main process
  logic       tx_en = 1'b1;
  logic [7:0] exp_q[$];

  initial begin
    bus.BUSY = 1'b0;
    forever begin
      @(posedge clk); #1;
      mon_nb = bus.BUSY;
      if (!rst) begin
        mon_phase = 0;
        mon_nb = 1'b0;
      end else begin
        case (mon_phase)
          0: if (tx_en && bus.sendEnable) begin
               mon_cap = bus.data;
               got_q.push_back(bus.data);
               mon_cnt = 0;
               mon_phase = 1;
             end
          1: begin
               if (!bus.sendEnable || bus.data !== mon_cap) hs_bad++;
               mon_cnt++;
               if (mon_cnt == 2) begin mon_nb = 1'b1; mon_cnt = 0; mon_phase = 2; end
             end
          2: begin
               if (bus.sendEnable || bus.data !== mon_cap) hs_bad++;
               mon_cnt++;
               if (mon_cnt == 16) begin mon_nb = 1'b0; mon_phase = 0; end
             end
          default: mon_phase = 0;
        endcase
      end
      #1 bus.BUSY = mon_nb;
      @(negedge clk);
      if (bus.frame_done) done_cnt++;
    end
  end

  // Pulses cnt_valid for one cycle; returns at +1 of the cycle after the pulse.
  task automatic start_frame(input logic [31:0] v);
    @(posedge clk); #1;
    bus.cnt_data  = v;
    bus.cnt_valid = 1'b1;
    @(posedge clk); #1;
    bus.cnt_valid = 1'b0;
  endtask

  // Returns at the negedge of the frame_done cycle, ok=0 if it never came.
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.cnt_valid = 1'b0;
    bus.cnt_data  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
    checks++; if (bus.sendEnable !== 1'b0) begin errors++; $display("FAIL reset_se: got %b want 0", bus.sendEnable); end
    checks++; if (bus.Status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", bus.Status); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_frame;
    int base;
    int d0;
    bit ok;
    base = got_q.size();
    d0 = done_cnt;
    start_frame(32'h12345678);
    checks++; if (bus.sendEnable !== 1'b1) begin errors++; $display("FAIL latency_se: got %b want 1", bus.sendEnable); end
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL latency_data: got %h want a5", bus.data); end
    checks++; if (bus.Status !== 2'b01) begin errors++; $display("FAIL latency_status: got %b want 01", bus.Status); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_timeout: got %b want 1", ok); end
    @(negedge clk);
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", bus.frame_done); end
    checks++; if (bus.Status !== 2'b00) begin errors++; $display("FAIL basic_idle: got %b want 00", bus.Status); end
    @(posedge clk); #1;
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - d0, 1); end
    exp_q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_q.size() <= base + k) begin errors++; $display("FAIL basic_byte%0d: got none want %h", k, exp_q[k]); end
      else if (got_q[base + k] !== exp_q[k]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", k, got_q[base + k], exp_q[k]); end
    end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", bus.overrun); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus.err); end
    checks++; if (hs_bad !== 0) begin errors++; $display("FAIL basic_handshake: got %0d violations want 0", hs_bad); end
  endtask

  task automatic test_overrun;
    int base;
    bit ok;
    bit seen;
    base = got_q.size();
    start_frame(32'h12345678);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (got_q.size() >= base + 3) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ovr_byte2_timeout: got %b want 1", seen); end
    bus.cnt_data  = 32'hFFFFFFFF;
    bus.cnt_valid = 1'b1;
    @(posedge clk); #1;
    bus.cnt_valid = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_done_timeout: got %b want 1", ok); end
    @(posedge clk); #1;
    exp_q = {8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_q.size() <= base + k) begin errors++; $display("FAIL ovr_byte%0d: got none want %h", k, exp_q[k]); end
      else if (got_q[base + k] !== exp_q[k]) begin errors++; $display("FAIL ovr_byte%0d: got %h want %h", k, got_q[base + k], exp_q[k]); end
    end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    checks++; if (hs_bad !== 0) begin errors++; $display("FAIL ovr_handshake: got %0d violations want 0", hs_bad); end
  endtask

  task automatic test_timeout;
    int d0;
    int se_cycles;
    d0 = done_cnt;
    tx_en = 1'b0;
    start_frame(32'h01020304);
    checks++; if (bus.sendEnable !== 1'b1) begin errors++; $display("FAIL to_accept_se: got %b want 1", bus.sendEnable); end
    se_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.sendEnable) break;
      se_cycles++;
      @(posedge clk); #1;
    end
    checks++; if (se_cycles !== 10) begin errors++; $display("FAIL to_se_cycles: got %0d want 10", se_cycles); end
    checks++; if (bus.Status !== 2'b11) begin errors++; $display("FAIL to_abort_status: got %b want 11", bus.Status); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", bus.err); end
    @(posedge clk); #1;
    checks++; if (bus.Status !== 2'b00) begin errors++; $display("FAIL to_idle: got %b want 00", bus.Status); end
    checks++; if (bus.sendEnable !== 1'b0) begin errors++; $display("FAIL to_idle_se: got %b want 0", bus.sendEnable); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", bus.err); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL to_no_done: got %0d want %0d", done_cnt, d0); end
    tx_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    int base;
    bit seen;
    base = got_q.size();
    start_frame(32'h12345678);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (got_q.size() >= base + 4) seen = 1'b1;
    end
    for (int i = 0; i < 20 && seen; i++) begin
      if (bus.Status === 2'b10) break;
      @(negedge clk);
    end
    checks++; if (bus.Status !== 2'b10) begin errors++; $display("FAIL rmf_shift3: got %b want 10", bus.Status); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.sendEnable !== 1'b0) begin errors++; $display("FAIL rmf_se: got %b want 0", bus.sendEnable); end
    checks++; if (bus.Status !== 2'b00) begin errors++; $display("FAIL rmf_status: got %b want 00", bus.Status); end
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL rmf_data: got %h want 00", bus.data); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rmf_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rmf_overrun: got %b want 0", bus.overrun); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rmf_err: got %b want 0", bus.err); end
    rst = 1'b1;
    start_frame(32'h12345678);
    checks++; if (bus.sendEnable !== 1'b1) begin errors++; $display("FAIL rmf_restart_se: got %b want 1", bus.sendEnable); end
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL rmf_restart_data: got %h want a5", bus.data); end
  endtask

  // Continues the frame restarted by test_reset_mid_frame.
  task automatic test_back_to_back;
    int base;
    bit ok;
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", ok); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_pre_overrun: got %b want 0", bus.overrun); end
    base = got_q.size();
    bus.cnt_data  = 32'h000000FF;
    bus.cnt_valid = 1'b1;               // lands on the frame_done cycle
    @(posedge clk); #1;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_drop: got %b want 1", bus.overrun); end
    checks++; if (bus.Status !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b want 00", bus.Status); end
    @(posedge clk); #1;                 // second pulse accepted in IDLE
    bus.cnt_valid = 1'b0;
    checks++; if (bus.sendEnable !== 1'b1) begin errors++; $display("FAIL b2b_accept_se: got %b want 1", bus.sendEnable); end
    wait_done(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b want 1", ok); end
    @(posedge clk); #1;
    exp_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_q.size() <= base + k) begin errors++; $display("FAIL b2b_byte%0d: got none want %h", k, exp_q[k]); end
      else if (got_q[base + k] !== exp_q[k]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", k, got_q[base + k], exp_q[k]); end
    end
    checks++; if (got_q.size() !== base + 6) begin errors++; $display("FAIL b2b_byte_count: got %0d want %0d", got_q.size() - base, 6); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky: got %b want 1", bus.overrun); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", bus.err); end
    checks++; if (hs_bad !== 0) begin errors++; $display("FAIL b2b_handshake: got %0d violations want 0", hs_bad); end
  endtask

  initial begin
    rst = 1'b0;
    bus.cnt_valid = 1'b0;
    bus.cnt_data  = 32'h0;
    test_reset();
    test_basic_frame();
    test_overrun();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
